w_stim_gen: RTL and testbench

- Serial stimulus transmitter that produces the single-bit `w` input consumed by the sequence-detector FSM (clk/rst/w/z).
- A pattern word and length are loaded, then shifted out LSB-first, one bit per clock, optionally looping.
- A built-in reference model generates `expect_z`. This is the value the detector's `z` must match: high once `w` has held the same value for 4 consecutive samples.
- Sits beside the detector in lab test harnesses and on-board demos, replacing hand-toggled switches.

---
 rtl/w_stim_gen_if.sv | 28 ++
 rtl/w_stim_gen.sv | 135 +++++++++++++
 tb/tb_w_stim_gen.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/w_stim_gen_if.sv
// Control and observation bundle for the w_stim_gen serial stimulus transmitter.
// The controller (harness or bench) uses the master view, the generator the slave view.
interface w_stim_gen_if #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned CNT_W   = 6
);
  logic               load;
  logic [MAX_LEN-1:0] pattern;
  logic [CNT_W-1:0]   len;
  logic               start;
  logic               repeat_en;
  logic               abort;
  logic               w;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   bit_idx;
  logic               expect_z;

  modport master (
    output load, pattern, len, start, repeat_en, abort,
    input  w, busy, done, bit_idx, expect_z
  );

  modport slave (
    input  load, pattern, len, start, repeat_en, abort,
    output w, busy, done, bit_idx, expect_z
  );
endinterface

// File: rtl/w_stim_gen.sv
// Serial stimulus source for the run-of-four sequence detector: shifts a loaded
// pattern out LSB-first on w and produces the detector's expected z alongside it.
module w_stim_gen #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  w_stim_gen_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [2:0]       RUN_SAT = 3'd4;

  state_t             state;
  logic [MAX_LEN-1:0] pat_reg;
  logic [MAX_LEN-1:0] sh_reg;
  logic [CNT_W-1:0]   len_reg;
  logic               prev_w;
  logic [2:0]         run_cnt;

  logic [MAX_LEN-1:0] src_pat;
  logic [CNT_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   src_len;
  logic               last_bit;
  logic [2:0]         run_next;

  // A start in the same cycle as load must see the incoming pattern/length.
  always_comb begin
    len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    src_pat     = bus.load ? bus.pattern : pat_reg;
    src_len     = bus.load ? len_clamped : len_reg;
    last_bit    = (bus.bit_idx == (len_reg - ONE));
    if (bus.w != prev_w) begin
      run_next = 3'd1;
    end else if (run_cnt >= RUN_SAT) begin
      run_next = RUN_SAT;
    end else begin
      run_next = run_cnt + 3'd1;
    end
  end

  // sh_reg holds the bits still to be sent, so w is always fed from bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pat_reg      <= '0;
      sh_reg       <= '0;
      len_reg      <= '0;
      prev_w       <= 1'b0;
      run_cnt      <= '0;
      bus.w        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bit_idx  <= '0;
      bus.expect_z <= 1'b0;
    end else begin
      prev_w       <= bus.w;
      run_cnt      <= run_next;
      bus.expect_z <= (run_next >= RUN_SAT);

      if (bus.abort) begin
        state       <= IDLE;
        bus.w       <= 1'b0;
        bus.busy    <= 1'b0;
        bus.done    <= 1'b0;
        bus.bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            bus.w       <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.bit_idx <= '0;
            if (bus.load) begin
              pat_reg <= bus.pattern;
              len_reg <= len_clamped;
            end
            if (bus.start) begin
              if (src_len != '0) begin
                state    <= SEND;
                bus.busy <= 1'b1;
                bus.w    <= src_pat[0];
                sh_reg   <= src_pat >> 1;
              end else begin
                state    <= DONE;
                bus.done <= 1'b1;
              end
            end
          end

          SEND: begin
            if (!last_bit) begin
              bus.bit_idx <= bus.bit_idx + ONE;
              bus.w       <= sh_reg[0];
              sh_reg      <= sh_reg >> 1;
            end else if (bus.repeat_en) begin
              bus.bit_idx <= '0;
              bus.w       <= pat_reg[0];
              sh_reg      <= pat_reg >> 1;
            end else begin
              state       <= DONE;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              bus.w       <= 1'b0;
              bus.bit_idx <= '0;
            end
          end

          DONE: begin
            state       <= IDLE;
            bus.done    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.w       <= 1'b0;
            bus.bit_idx <= '0;
          end

          default: begin
            state       <= IDLE;
            bus.w       <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.bit_idx <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_w_stim_gen.sv
// Randomised bench for w_stim_gen: a stream-level model predicts w, busy, done and
// bit_idx per cycle, and expect_z from a window of the last four sampled w values.
module tb_w_stim_gen;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned CNT_W   = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec  = 0;
  int   errs = 0;

  w_stim_gen_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) sif ();

  w_stim_gen #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  logic        cur_w = 1'b0;
  logic        hist[$];
  logic [31:0] m_pat = '0;
  int          m_len = 0;

  function automatic logic pbit(input logic [31:0] p, input int k);
    return p[k[4:0]];
  endfunction

  // Detector expectation: the last four w samples taken at clock edges are equal.
  function automatic logic zm();
    int n;
    n = hist.size();
    if (n < 4) return 1'b0;
    for (int i = 1; i < 4; i++)
      if (hist[n-1-i] !== hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick(input logic next_w);
    @(posedge clk);
    if (rst) begin
      hist.push_back(cur_w);
      if (hist.size() > 4) void'(hist.pop_front());
      cur_w = next_w;
    end else begin
      hist.delete();
      cur_w = 1'b0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    sif.load      = 1'b0;
    sif.start     = 1'b0;
    sif.abort     = 1'b0;
    sif.repeat_en = 1'b0;
    sif.pattern   = '0;
    sif.len       = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      vec++;
      if ({sif.w, sif.busy, sif.done, sif.bit_idx, sif.expect_z} !== '0) begin
        errs++;
        $display("FAIL reset_outs cyc=%0d got w=%b busy=%b done=%b idx=%0d z=%b exp all 0",
                 c, sif.w, sif.busy, sif.done, sif.bit_idx, sif.expect_z);
      end
    end
    #3 rst = 1'b1;
    m_pat = '0;
    m_len = 0;
    for (int c = 1; c <= 6; c++) begin
      tick(1'b0);
      vec++;
      if (sif.expect_z !== (c >= 4)) begin
        errs++;
        $display("FAIL idle_z edge=%0d got=%b exp=%b", c, sif.expect_z, (c >= 4));
      end
      vec++;
      if ({sif.w, sif.busy, sif.done, sif.bit_idx} !== '0) begin
        errs++;
        $display("FAIL idle_outs edge=%0d got w=%b busy=%b done=%b idx=%0d exp all 0",
                 c, sif.w, sif.busy, sif.done, sif.bit_idx);
      end
    end
  endtask

  task automatic test_send();
    logic [31:0] pat;
    int          len_in, n_idle;
    bit          same, do_load, noise;
    for (int it = 0; it < 10; it++) begin
      pat     = $urandom;
      len_in  = $urandom_range(1, 40);
      same    = 1'($urandom_range(0, 1));
      do_load = 1'b1;
      noise   = (it >= 2);
      n_idle  = $urandom_range(0, 5);
      if (it == 0) begin pat = 32'h0F3; len_in = 12; same = 1'b0; n_idle = 4; end
      if (it == 1) len_in = 40;
      if (it >= 3 && $urandom_range(0, 2) == 0) do_load = 1'b0;
      if (do_load) begin
        m_pat = pat;
        m_len = (len_in > 32) ? 32 : len_in;
      end
      repeat (n_idle) tick(1'b0);
      if (do_load && !same) begin
        sif.load = 1'b1; sif.pattern = pat; sif.len = CNT_W'(len_in);
        tick(1'b0);
        sif.load = 1'b0;
      end
      sif.load    = do_load && same;
      sif.pattern = pat;
      sif.len     = CNT_W'(len_in);
      sif.start   = 1'b1;
      for (int k = 0; k <= m_len + 1; k++) begin
        tick((k < m_len) ? pbit(m_pat, k) : 1'b0);
        vec++;
        if (sif.w !== cur_w) begin
          errs++; $display("FAIL send_w it=%0d k=%0d got=%b exp=%b", it, k, sif.w, cur_w);
        end
        vec++;
        if (sif.busy !== (k < m_len)) begin
          errs++; $display("FAIL send_busy it=%0d k=%0d got=%b exp=%b", it, k, sif.busy, (k < m_len));
        end
        vec++;
        if (sif.done !== (k == m_len)) begin
          errs++; $display("FAIL send_done it=%0d k=%0d got=%b exp=%b", it, k, sif.done, (k == m_len));
        end
        vec++;
        if (sif.bit_idx !== CNT_W'((k < m_len) ? k : 0)) begin
          errs++; $display("FAIL send_idx it=%0d k=%0d got=%0d exp=%0d", it, k, sif.bit_idx, (k < m_len) ? k : 0);
        end
        vec++;
        if (sif.expect_z !== zm()) begin
          errs++; $display("FAIL send_z it=%0d k=%0d got=%b exp=%b", it, k, sif.expect_z, zm());
        end
        if (noise && k <= m_len) begin
          sif.start = 1'($urandom); sif.load = 1'($urandom);
          sif.pattern = $urandom;   sif.len = CNT_W'($urandom);
        end else begin
          sif.start = 1'b0; sif.load = 1'b0;
        end
      end
      tick(1'b0);
      vec++;
      if ({sif.busy, sif.done, sif.w} !== 3'b000) begin
        errs++; $display("FAIL send_after it=%0d got busy=%b done=%b w=%b exp 0", it, sif.busy, sif.done, sif.w);
      end
    end
  endtask

  task automatic test_repeat();
    logic [31:0] pat;
    int          L, P, total;
    for (int it = 0; it < 6; it++) begin
      pat = $urandom;
      L   = $urandom_range(1, 6);
      P   = $urandom_range(1, 4);
      if (it == 0) begin pat = 32'h3; L = 2; P = 5; end
      total = P * L;
      m_pat = pat;
      m_len = L;
      repeat ($urandom_range(0, 4)) tick(1'b0);
      sif.load = 1'b1; sif.pattern = pat; sif.len = CNT_W'(L);
      sif.start = 1'b1; sif.repeat_en = 1'b1;
      for (int k = 0; k <= total + 1; k++) begin
        tick((k < total) ? pbit(pat, k % L) : 1'b0);
        vec++;
        if (sif.w !== cur_w) begin
          errs++; $display("FAIL rep_w it=%0d k=%0d got=%b exp=%b", it, k, sif.w, cur_w);
        end
        vec++;
        if (sif.busy !== (k < total)) begin
          errs++; $display("FAIL rep_busy it=%0d k=%0d got=%b exp=%b", it, k, sif.busy, (k < total));
        end
        vec++;
        if (sif.done !== (k == total)) begin
          errs++; $display("FAIL rep_done it=%0d k=%0d got=%b exp=%b", it, k, sif.done, (k == total));
        end
        vec++;
        if (sif.bit_idx !== CNT_W'((k < total) ? (k % L) : 0)) begin
          errs++; $display("FAIL rep_idx it=%0d k=%0d got=%0d exp=%0d", it, k, sif.bit_idx, (k < total) ? (k % L) : 0);
        end
        vec++;
        if (sif.expect_z !== zm()) begin
          errs++; $display("FAIL rep_z it=%0d k=%0d got=%b exp=%b", it, k, sif.expect_z, zm());
        end
        sif.load = 1'b0; sif.start = 1'b0;
        if (k == (P - 1) * L) sif.repeat_en = 1'b0;
      end
    end
  endtask

  task automatic test_len_zero();
    for (int v = 0; v < 2; v++) begin
      repeat (2) tick(1'b0);
      sif.pattern = $urandom | 32'h1; sif.len = '0; sif.load = 1'b1;
      if (v == 1) begin tick(1'b0); sif.load = 1'b0; end
      sif.start = 1'b1;
      m_pat = sif.pattern; m_len = 0;
      tick(1'b0);
      sif.load = 1'b0; sif.start = 1'b0;
      vec++;
      if ({sif.done, sif.busy, sif.w, sif.bit_idx} !== {1'b1, 1'b0, 1'b0, CNT_W'(0)}) begin
        errs++; $display("FAIL len0_done v=%0d got done=%b busy=%b w=%b idx=%0d exp done=1 rest 0",
                         v, sif.done, sif.busy, sif.w, sif.bit_idx);
      end
      tick(1'b0);
      vec++;
      if ({sif.done, sif.busy} !== 2'b00) begin
        errs++; $display("FAIL len0_after v=%0d got done=%b busy=%b exp 00", v, sif.done, sif.busy);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] pat;
    int          L, ab, chk;
    for (int it = 0; it < 4; it++) begin
      pat = $urandom;
      L   = (it == 0) ? 12 : $urandom_range(2, 32);
      ab  = (it == 0) ? 5 : $urandom_range(0, L - 1);
      m_pat = pat; m_len = L;
      repeat ($urandom_range(0, 3)) tick(1'b0);
      sif.load = 1'b1; sif.pattern = pat; sif.len = CNT_W'(L); sif.start = 1'b1;
      for (int k = 0; k <= ab; k++) begin
        tick(pbit(pat, k));
        sif.load = 1'b0; sif.start = 1'b0;
        vec++;
        if ({sif.w, sif.bit_idx} !== {cur_w, CNT_W'(k)}) begin
          errs++; $display("FAIL abort_pre it=%0d k=%0d got w=%b idx=%0d exp w=%b idx=%0d",
                           it, k, sif.w, sif.bit_idx, cur_w, k);
        end
      end
      sif.abort = 1'b1; sif.start = 1'b1;
      tick(1'b0);
      sif.abort = 1'b0; sif.start = 1'b0;
      vec++;
      if ({sif.w, sif.busy, sif.done, sif.bit_idx} !== '0) begin
        errs++; $display("FAIL abort_stop it=%0d got w=%b busy=%b done=%b idx=%0d exp all 0",
                         it, sif.w, sif.busy, sif.done, sif.bit_idx);
      end
      tick(1'b0);
      vec++;
      if ({sif.busy, sif.done, sif.expect_z} !== {2'b00, zm()}) begin
        errs++; $display("FAIL abort_after it=%0d got busy=%b done=%b z=%b exp 0 0 %b",
                         it, sif.busy, sif.done, sif.expect_z, zm());
      end
      chk = (L < 4) ? L : 4;
      sif.start = 1'b1;
      for (int k = 0; k < chk; k++) begin
        tick(pbit(pat, k));
        sif.start = 1'b0;
        vec++;
        if ({sif.w, sif.busy, sif.bit_idx} !== {cur_w, 1'b1, CNT_W'(k)}) begin
          errs++; $display("FAIL abort_resend it=%0d k=%0d got w=%b busy=%b idx=%0d exp w=%b busy=1 idx=%0d",
                           it, k, sif.w, sif.busy, sif.bit_idx, cur_w, k);
        end
      end
      sif.abort = 1'b1;
      tick(1'b0);
      sif.abort = 1'b0;
    end
    // abort in IDLE must also block a simultaneous load and start
    sif.abort = 1'b1; sif.load = 1'b1; sif.start = 1'b1;
    sif.pattern = ~m_pat; sif.len = CNT_W'(5);
    tick(1'b0);
    sif.abort = 1'b0; sif.load = 1'b0;
    vec++;
    if ({sif.busy, sif.done, sif.w} !== 3'b000) begin
      errs++; $display("FAIL abort_idle got busy=%b done=%b w=%b exp 000", sif.busy, sif.done, sif.w);
    end
    tick(pbit(m_pat, 0));
    sif.start = 1'b0;
    vec++;
    if ({sif.busy, sif.w} !== {1'b1, cur_w}) begin
      errs++; $display("FAIL abort_noload got busy=%b w=%b exp busy=1 w=%b", sif.busy, sif.w, cur_w);
    end
    sif.abort = 1'b1;
    tick(1'b0);
    sif.abort = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] pat;
    pat = $urandom | 32'h80;
    m_pat = pat; m_len = 12;
    tick(1'b0);
    sif.load = 1'b1; sif.pattern = pat; sif.len = CNT_W'(12); sif.start = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick(pbit(pat, k));
      sif.load = 1'b0; sif.start = 1'b0;
    end
    vec++;
    if ({sif.w, sif.busy, sif.bit_idx} !== {1'b1, 1'b1, CNT_W'(7)}) begin
      errs++; $display("FAIL arst_pre got w=%b busy=%b idx=%0d exp w=1 busy=1 idx=7", sif.w, sif.busy, sif.bit_idx);
    end
    #3 rst = 1'b0;
    hist.delete(); cur_w = 1'b0;
    #1;
    vec++;
    if ({sif.w, sif.busy, sif.done, sif.bit_idx, sif.expect_z} !== '0) begin
      errs++; $display("FAIL arst_now got w=%b busy=%b done=%b idx=%0d z=%b exp all 0",
                       sif.w, sif.busy, sif.done, sif.bit_idx, sif.expect_z);
    end
    tick(1'b0);
    #2 rst = 1'b1;
    m_pat = '0; m_len = 0;
    for (int c = 1; c <= 5; c++) begin
      tick(1'b0);
      vec++;
      if ({sif.w, sif.busy, sif.done, sif.expect_z} !== {3'b000, zm()}) begin
        errs++; $display("FAIL arst_idle c=%0d got w=%b busy=%b done=%b z=%b exp 0 0 0 %b",
                         c, sif.w, sif.busy, sif.done, sif.expect_z, zm());
      end
    end
    // length register was cleared, so a bare start completes without sending
    sif.start = 1'b1;
    tick(1'b0);
    sif.start = 1'b0;
    vec++;
    if ({sif.done, sif.busy} !== 2'b10) begin
      errs++; $display("FAIL arst_len0 got done=%b busy=%b exp done=1 busy=0", sif.done, sif.busy);
    end
    tick(1'b0);
    vec++;
    if (sif.done !== 1'b0) begin
      errs++; $display("FAIL arst_done_clr got=%b exp=0", sif.done);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_send();
    test_repeat();
    test_len_zero();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
